// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-master, multi-slave bus arbiter. Masters hold a level request until
// their transfer finishes. The slave answers with a one-cycle tx_done or
// rx_done pulse. When both masters request at once, round-robin decides.
//
// The state register changes on the edge that samples a request. Every output
// is re-registered from that state, so a grant becomes visible one cycle later.
// slave_sel and m_sel are loaded on grant entry. They are therefore stable
// before the grant appears and do not move while it is held.
//
// Optional feature (macro ARB_TIMEOUT_EN): a watchdog forces a release after
// TIMEOUT_CYCLES granted cycles and pulses timeout. Without the macro, no
// counter is built, timeout is tied low, and a grant lasts until done or abort.
//
// Parameters
//   SLV_BITS        width of the slave-select field
//   TIMEOUT_CYCLES  maximum grant length when the watchdog is compiled in
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous, active-low reset
//   m1_req, m2_req      master bus requests (level)
//   m1_slave, m2_slave  target slave id of each master
//   tx_done, rx_done    transfer-complete pulses from the selected slave
//   m1_grant, m2_grant  bus ownership, never both high
//   m_sel               master mux select (0 = master 1, 1 = master 2)
//   slave_sel           slave demux select, latched at grant
//   bus_busy            high while a grant is active
//   timeout             one-cycle pulse on a watchdog release
// -----------------------------------------------------------------------------
module bus_arbiter #(
   parameter int SLV_BITS       = 2,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                m1_req,
   input  logic                m2_req,
   input  logic [SLV_BITS-1:0] m1_slave,
   input  logic [SLV_BITS-1:0] m2_slave,
   input  logic                tx_done,
   input  logic                rx_done,
   output logic                m1_grant,
   output logic                m2_grant,
   output logic                m_sel,
   output logic [SLV_BITS-1:0] slave_sel,
   output logic                bus_busy,
   output logic                timeout
);

   typedef enum logic [1:0] {IDLE, GRANT1, GRANT2, RELEASE} state_t;

   state_t state;
   state_t next_state;
   logic   last_m2;
   logic   done;
   logic   granted;
   logic   wd_fire;
   logic   enter_g1;
   logic   enter_g2;

   assign done     = tx_done | rx_done;
   assign granted  = (state == GRANT1) || (state == GRANT2);
   assign enter_g1 = (state == IDLE) && (next_state == GRANT1);
   assign enter_g2 = (state == IDLE) && (next_state == GRANT2);

   // Next-state logic. Done pulses only matter in a grant state. On a
   // conflict, the grant goes to the master that was not served last.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (m1_req && m2_req)
               next_state = last_m2 ? GRANT1 : GRANT2;
            else if (m1_req)
               next_state = GRANT1;
            else if (m2_req)
               next_state = GRANT2;
         end
         GRANT1: if (done || !m1_req || wd_fire) next_state = RELEASE;
         GRANT2: if (done || !m2_req || wd_fire) next_state = RELEASE;
         RELEASE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State and output registers. Grants and bus_busy follow the state one
   // cycle later. Reset drops them at once and skips the RELEASE state.
   // last_m2 resets to 1, so the first conflict goes to master 1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         m1_grant  <= 1'b0;
         m2_grant  <= 1'b0;
         bus_busy  <= 1'b0;
         m_sel     <= 1'b0;
         slave_sel <= '0;
         last_m2   <= 1'b1;
      end else begin
         state    <= next_state;
         m1_grant <= (state == GRANT1);
         m2_grant <= (state == GRANT2);
         bus_busy <= granted;
         if (enter_g1) begin
            slave_sel <= m1_slave;
            m_sel     <= 1'b0;
            last_m2   <= 1'b0;
         end else if (enter_g2) begin
            slave_sel <= m2_slave;
            m_sel     <= 1'b1;
            last_m2   <= 1'b1;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] wd_count;
   logic             wd_hit;
   logic             cur_req;

   assign cur_req = (state == GRANT1) ? m1_req : m2_req;
   assign wd_fire = granted && (wd_count == CNT_W'(TIMEOUT_CYCLES - 1));

   // The watchdog counts granted cycles from grant entry. wd_hit records
   // that a release came from the watchdog, not from done or abort, so the
   // timeout pulse lines up with the cycle in which the grant drops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wd_count <= '0;
         wd_hit   <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         if (enter_g1 || enter_g2)
            wd_count <= '0;
         else if (granted)
            wd_count <= wd_count + 1'b1;
         if (granted)
            wd_hit <= wd_fire && !done && cur_req;
         timeout <= (state == RELEASE) && wd_hit;
      end
   end
`else
   // The watchdog length only matters when the watchdog is compiled in.
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign wd_fire            = 1'b0;
   assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed bench for bus_arbiter. It covers reset, stray done pulses, a single
// grant, round-robin alternation, abort, asynchronous reset during a grant,
// and the watchdog (or persistent grant when ARB_TIMEOUT_EN is undefined).
// Inputs change and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

   logic       clk;
   logic       reset;
   logic       m1_req;
   logic       m2_req;
   logic [1:0] m1_slave;
   logic [1:0] m2_slave;
   logic       tx_done;
   logic       rx_done;
   logic       m1_grant;
   logic       m2_grant;
   logic       m_sel;
   logic [1:0] slave_sel;
   logic       bus_busy;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   bus_arbiter #(.SLV_BITS(2), .TIMEOUT_CYCLES(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .m1_req   (m1_req),
      .m2_req   (m2_req),
      .m1_slave (m1_slave),
      .m2_slave (m2_slave),
      .tx_done  (tx_done),
      .rx_done  (rx_done),
      .m1_grant (m1_grant),
      .m2_grant (m2_grant),
      .m_sel    (m_sel),
      .slave_sel(slave_sel),
      .bus_busy (bus_busy),
      .timeout  (timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence below ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL sim_time_limit observed=running expected=finished");
      $fatal(1, "[TB] time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
         $error("[TB] check %s", tag);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_m1_grant"}, 32'(m1_grant), 32'd0);
      check({tag, "_m2_grant"}, 32'(m2_grant), 32'd0);
      check({tag, "_bus_busy"}, 32'(bus_busy), 32'd0);
   endtask

   initial begin
      reset    = 1'b1;
      m1_req   = 1'b0;
      m2_req   = 1'b0;
      m1_slave = 2'd0;
      m2_slave = 2'd0;
      tx_done  = 1'b0;
      rx_done  = 1'b0;

      // Reset state
      #2 reset = 1'b0;
      #1;
      check_idle_outputs("reset");
      check("reset_m_sel", 32'(m_sel), 32'd0);
      check("reset_slave_sel", 32'(slave_sel), 32'd0);
      check("reset_timeout", 32'(timeout), 32'd0);
      tick();
      reset = 1'b1;

      // A stray done pulse in IDLE is ignored
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      tick();
      check_idle_outputs("stray");
      check("stray_slave_sel", 32'(slave_sel), 32'd0);
      check("stray_m_sel", 32'(m_sel), 32'd0);

      // Single request from master 1 to slave 2, finished by rx_done
      m1_req   = 1'b1;
      m1_slave = 2'd2;
      tick();
      check("single_latency_grant", 32'(m1_grant), 32'd0);
      check("single_slave_sel", 32'(slave_sel), 32'd2);
      tick();
      check("single_m1_grant", 32'(m1_grant), 32'd1);
      check("single_m2_grant", 32'(m2_grant), 32'd0);
      check("single_m_sel", 32'(m_sel), 32'd0);
      check("single_bus_busy", 32'(bus_busy), 32'd1);
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      m1_req  = 1'b0;
      tick();
      check_idle_outputs("single_release");
      tick();
      check_idle_outputs("single_idle");

      // Asynchronous reset during GRANT1
      m1_req   = 1'b1;
      m1_slave = 2'd1;
      tick();
      tick();
      check("areset_pre_grant", 32'(m1_grant), 32'd1);
      #2 reset = 1'b0;
      #1;
      check_idle_outputs("areset");
      check("areset_slave_sel", 32'(slave_sel), 32'd0);
      m1_req = 1'b0;
      #1 reset = 1'b1;
      tick();

      // Conflict right after reset: master 1 wins, then the masters alternate
      m1_req   = 1'b1;
      m2_req   = 1'b1;
      m1_slave = 2'd1;
      m2_slave = 2'd3;
      tick();
      check("conf1_m_sel", 32'(m_sel), 32'd0);
      check("conf1_slave_sel", 32'(slave_sel), 32'd1);
      tick();
      check("conf1_m1_grant", 32'(m1_grant), 32'd1);
      check("conf1_m2_grant", 32'(m2_grant), 32'd0);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      tick();
      check_idle_outputs("conf1_release");
      tick();
      check("conf2_m_sel", 32'(m_sel), 32'd1);
      check("conf2_slave_sel", 32'(slave_sel), 32'd3);
      check("conf2_latency_grant", 32'(m2_grant), 32'd0);
      tick();
      check("conf2_m2_grant", 32'(m2_grant), 32'd1);
      check("conf2_m1_grant", 32'(m1_grant), 32'd0);
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      tick();
      check_idle_outputs("conf2_release");
      tick();
      check("conf3_m_sel", 32'(m_sel), 32'd0);
      tick();
      check("conf3_m1_grant", 32'(m1_grant), 32'd1);

      // Abort: master 2 is granted, then drops its request without a done
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      tick();
      tick();
      tick();
      check("abort_m2_grant", 32'(m2_grant), 32'd1);
      m2_req = 1'b0;
      tick();
      m2_req = 1'b1;
      tick();
      check_idle_outputs("abort_release");
      tick();
      check("abort_next_m_sel", 32'(m_sel), 32'd0);
      check("abort_next_slave_sel", 32'(slave_sel), 32'd1);
      tick();
      check("abort_next_m1_grant", 32'(m1_grant), 32'd1);

      // Grant held with no done: watchdog release, or a grant that persists
`ifdef ARB_TIMEOUT_EN
      for (int i = 0; i < 7; i++) begin
         tick();
         check("wd_hold_grant", 32'(m1_grant), 32'd1);
         check("wd_hold_timeout", 32'(timeout), 32'd0);
      end
      tick();
      check("wd_fire_grant", 32'(m1_grant), 32'd0);
      check("wd_fire_timeout", 32'(timeout), 32'd1);
      tick();
      check("wd_pulse_end", 32'(timeout), 32'd0);
      tick();
      check("wd_regrant_m2", 32'(m2_grant), 32'd1);
      check("wd_regrant_m1", 32'(m1_grant), 32'd0);
`else
      for (int i = 0; i < 20; i++) begin
         tick();
         check("hold_grant", 32'(m1_grant), 32'd1);
         check("hold_timeout", 32'(timeout), 32'd0);
      end
`endif

      m1_req = 1'b0;
      m2_req = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
